dma_ctrl: RTL

//  Single-channel DMA sequencer: copies cfg_len 32-bit words from cfg_src to cfg_dst over one DATA_BUS master port.

---
 rtl/dma_pkg.sv | 37 +++
 rtl/dma_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module : dma_pkg
// Purpose: Shared types and bit-index constants for the single-channel DMA
//          sequencer (dma_ctrl). Holds the sequencer state encoding and the
//          bit positions used by software for the ctrl and status words.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FIN     = 3'd5
  } dma_state_t;

  // ctrl word bit positions
  localparam int CTRL_START = 0;

  // status word bit positions
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERR   = 2;
  localparam int STAT_ABORT = 3;

  // A transfer is in progress whenever the sequencer owns the bus or is
  // waiting on a response.
  function automatic logic state_is_busy(input dma_state_t s);
    return (s == RD_REQ) || (s == RD_WAIT) || (s == WR_REQ) || (s == WR_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dma_ctrl
// Purpose: Single-channel DMA sequencer. Copies cfg_len 32-bit words from
//          cfg_src to cfg_dst over one master bus port, one word in flight at
//          a time (read, then write, then next word).
// Ports  : clk, rst_n (async, active-low)
//          cfg_src/cfg_dst/cfg_len  register-bank config (latched on start)
//          cfg_start                ctrl start level; rising edge starts
//          busy_o/done_o/err_o      status (done/err sticky until next start)
//          dmst_*                   master bus: req/gnt/we/addr/wdata,
//                                   rdata/rvalid/err response
//          abort_i/aborted_o        only with DMA_CTRL_ABORT_EN defined
// Config : DMA_CTRL_ABORT_EN adds the abort input and sticky aborted status.
// Rev    : 1.0  initial release
// ============================================================================
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int LEN_W    = 16,
  parameter int ADDR_INC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cfg_src,
  input  logic [31:0] cfg_dst,
  input  logic [31:0] cfg_len,
  input  logic        cfg_start,
`ifdef DMA_CTRL_ABORT_EN
  input  logic        abort_i,
  output logic        aborted_o,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        dmst_req,
  output logic        dmst_we,
  output logic [31:0] dmst_addr,
  output logic [31:0] dmst_wdata,
  input  logic        dmst_gnt,
  input  logic [31:0] dmst_rdata,
  input  logic        dmst_rvalid,
  input  logic        dmst_err
);

  dma_state_t        state, state_d;
  logic              start_q, armed_q;
  logic [31:0]       ptr_src, ptr_src_d;
  logic [31:0]       ptr_dst, ptr_dst_d;
  logic [31:0]       rd_buf, rd_buf_d;
  logic [LEN_W-1:0]  cnt, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              start_pulse;
  logic [LEN_W-1:0]  len_req;
`ifdef DMA_CTRL_ABORT_EN
  logic              abort_pend, abort_pend_d;
  logic              aborted_q, aborted_d;
`endif

  // Upper length bits and the byte-offset bits of the addresses are don't-care.
  logic unused_cfg;
  assign unused_cfg = ^{cfg_len[31:LEN_W], cfg_src[1:0], cfg_dst[1:0]};

  assign len_req = cfg_len[LEN_W-1:0];

  // armed_q stays low until cfg_start has been seen low once after reset, so
  // a start level held across reset is not mistaken for a fresh edge.
  assign start_pulse = cfg_start & ~start_q & armed_q;

  assign done_o = done_q;
  assign err_o  = err_q;
`ifdef DMA_CTRL_ABORT_EN
  assign aborted_o = aborted_q;
`endif

  always_comb begin
    state_d    = state;
    ptr_src_d  = ptr_src;
    ptr_dst_d  = ptr_dst;
    rd_buf_d   = rd_buf;
    cnt_d      = cnt;
    done_d     = done_q;
    err_d      = err_q;
`ifdef DMA_CTRL_ABORT_EN
    abort_pend_d = abort_pend;
    aborted_d    = aborted_q;
`endif
    busy_o     = state_is_busy(state);
    dmst_req   = 1'b0;
    dmst_we    = 1'b0;
    dmst_addr  = '0;
    dmst_wdata = '0;

    case (state)
      IDLE, FIN: begin
        if (start_pulse) begin
          ptr_src_d = {cfg_src[31:2], 2'b00};
          ptr_dst_d = {cfg_dst[31:2], 2'b00};
          cnt_d     = len_req;
          done_d    = 1'b0;
          err_d     = 1'b0;
`ifdef DMA_CTRL_ABORT_EN
          abort_pend_d = 1'b0;
          aborted_d    = 1'b0;
`endif
          if (len_req != '0) begin
            state_d = RD_REQ;
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end

      RD_REQ: begin
        dmst_req  = 1'b1;
        dmst_addr = ptr_src;
        if (dmst_gnt) begin
          state_d = RD_WAIT;
`ifdef DMA_CTRL_ABORT_EN
          // granted access must still complete; remember the abort
          if (abort_i) abort_pend_d = 1'b1;
`endif
        end
`ifdef DMA_CTRL_ABORT_EN
        else if (abort_i) begin
          state_d   = FIN;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
`endif
      end

      RD_WAIT: begin
`ifdef DMA_CTRL_ABORT_EN
        if (abort_i) abort_pend_d = 1'b1;
`endif
        if (dmst_rvalid) begin
          if (dmst_err) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
`ifdef DMA_CTRL_ABORT_EN
          else if (abort_pend_d) begin
            state_d   = FIN;
            done_d    = 1'b1;
            aborted_d = 1'b1;
          end
`endif
          else begin
            rd_buf_d = dmst_rdata;
            state_d  = WR_REQ;
          end
        end
      end

      WR_REQ: begin
        dmst_req   = 1'b1;
        dmst_we    = 1'b1;
        dmst_addr  = ptr_dst;
        dmst_wdata = rd_buf;
        if (dmst_gnt) begin
          state_d = WR_WAIT;
`ifdef DMA_CTRL_ABORT_EN
          if (abort_i) abort_pend_d = 1'b1;
`endif
        end
`ifdef DMA_CTRL_ABORT_EN
        else if (abort_i) begin
          state_d   = FIN;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
`endif
      end

      WR_WAIT: begin
`ifdef DMA_CTRL_ABORT_EN
        if (abort_i) abort_pend_d = 1'b1;
`endif
        if (dmst_rvalid) begin
          if (dmst_err) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            // pointers wrap modulo 2^32 naturally
            ptr_src_d = ptr_src + 32'(ADDR_INC);
            ptr_dst_d = ptr_dst + 32'(ADDR_INC);
            cnt_d     = cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              state_d = FIN;
              done_d  = 1'b1;
            end
`ifdef DMA_CTRL_ABORT_EN
            else if (abort_pend_d) begin
              state_d   = FIN;
              done_d    = 1'b1;
              aborted_d = 1'b1;
            end
`endif
            else begin
              state_d = RD_REQ;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      ptr_src <= '0;
      ptr_dst <= '0;
      rd_buf  <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMA_CTRL_ABORT_EN
      abort_pend <= 1'b0;
      aborted_q  <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      start_q <= cfg_start;
      armed_q <= armed_q | ~cfg_start;
      ptr_src <= ptr_src_d;
      ptr_dst <= ptr_dst_d;
      rd_buf  <= rd_buf_d;
      cnt     <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef DMA_CTRL_ABORT_EN
      abort_pend <= abort_pend_d;
      aborted_q  <= aborted_d;
`endif
    end
  end

endmodule
`default_nettype wire
